// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: plays short square-wave tone bursts for game events,
// arbitrating overlapping requests by fixed priority (LOSE > BLOCK > PADDLE > WALL).
// Lower-priority requests queue as one pending bit per effect.
`timescale 1ns/1ps
module sfx_scheduler #(
  parameter int TICK_CYCLES = 40000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [3:0]  REQ,
  output logic        SFX_AUDIO,
  output logic        BUSY,
  output logic [1:0]  ACTIVE_ID,
  output logic [16:0] TONE_HALF
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    active_id;
  logic [1:0]    note_idx;
  logic [3:0]    pending;
  logic [16:0]   tone_half;
  logic [6:0]    dur;
  logic [16:0]   tone_cnt;
  logic [PW-1:0] presc;
  logic [6:0]    tick_cnt;
  logic          tone_reg;

  logic [3:0]    pnd_all;
  logic [1:0]    req_top;
  logic [1:0]    pnd_top;
  logic          takeover;
  logic [23:0]   rom;
  logic          tick_wrap;
  logic          note_end;
  logic          tone_wrap;

  // Note ROM: {duration ticks, half-period cycles} for each effect/note.
  function automatic logic [23:0] note_rom(input logic [1:0] id, input logic [1:0] idx);
    logic [16:0] half;
    logic [6:0]  d;
    half = 17'd0;
    d    = 7'd0;
    case (id)
      2'd0: begin half = 17'd22727; d = 7'd20; end
      2'd1: begin half = 17'd45455; d = 7'd30; end
      2'd2: begin
        d    = 7'd15;
        half = (idx == 2'd0) ? 17'd15163 : 17'd11364;
      end
      default: begin
        d = 7'd100;
        case (idx)
          2'd0:    half = 17'd51020;
          2'd1:    half = 17'd60606;
          2'd2:    half = 17'd76336;
          default: half = 17'd102041;
        endcase
      end
    endcase
    return {d, half};
  endfunction

  // Index of the final note of each effect.
  function automatic logic [1:0] last_idx(input logic [1:0] id);
    case (id)
      2'd2:    return 2'd1;
      2'd3:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Highest-priority set bit (bit 3 wins); 0 when nothing is set.
  function automatic logic [1:0] top_bit(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

  // Arbitration and note-timing decode for the current cycle.
  always_comb begin
    pnd_all   = pending | REQ;
    req_top   = top_bit(REQ);
    pnd_top   = top_bit(pnd_all);
    takeover  = (state != IDLE) && (REQ != 4'd0) && (req_top >= active_id);
    rom       = note_rom(active_id, note_idx);
    tick_wrap = (presc == TICK_LAST);
    note_end  = tick_wrap && ((tick_cnt + 7'd1) == dur);
    tone_wrap = (tone_cnt == (tone_half - 17'd1));
  end

  // Scheduler state machine: arbitration, note loading and tone/tick timing.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      active_id <= 2'd0;
      note_idx  <= 2'd0;
      pending   <= 4'd0;
      tone_half <= 17'd0;
      dur       <= 7'd0;
      tone_cnt  <= 17'd0;
      presc     <= '0;
      tick_cnt  <= 7'd0;
      tone_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pnd_all != 4'd0) begin
            active_id <= pnd_top;
            note_idx  <= 2'd0;
            pending   <= pnd_all & ~onehot(pnd_top);
            state     <= LOAD;
          end
        end
        LOAD, PLAY: begin
          if (takeover) begin
            // Equal or higher request preempts/restarts; the aborted effect is dropped.
            active_id <= req_top;
            note_idx  <= 2'd0;
            pending   <= pnd_all & ~onehot(req_top);
            state     <= LOAD;
          end else if (state == LOAD) begin
            pending   <= pnd_all;
            tone_half <= rom[16:0];
            dur       <= rom[23:17];
            tone_cnt  <= 17'd0;
            presc     <= '0;
            tick_cnt  <= 7'd0;
            tone_reg  <= 1'b1;
            state     <= PLAY;
          end else begin
            pending <= pnd_all;
            if (tone_wrap) begin
              tone_cnt <= 17'd0;
              tone_reg <= ~tone_reg;
            end else begin
              tone_cnt <= tone_cnt + 17'd1;
            end
            if (tick_wrap) begin
              presc    <= '0;
              tick_cnt <= tick_cnt + 7'd1;
            end else begin
              presc <= presc + 1'b1;
            end
            if (note_end) begin
              if (note_idx != last_idx(active_id)) begin
                note_idx <= note_idx + 2'd1;
                state    <= LOAD;
              end else if (pnd_all != 4'd0) begin
                active_id <= pnd_top;
                note_idx  <= 2'd0;
                pending   <= pnd_all & ~onehot(pnd_top);
                state     <= LOAD;
              end else begin
                state     <= IDLE;
                active_id <= 2'd0;
                note_idx  <= 2'd0;
                tone_half <= 17'd0;
                dur       <= 7'd0;
                tone_cnt  <= 17'd0;
                presc     <= '0;
                tick_cnt  <= 7'd0;
                tone_reg  <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign SFX_AUDIO = tone_reg & (state == PLAY);
  assign BUSY      = (state != IDLE);
  assign ACTIVE_ID = active_id;
  assign TONE_HALF = tone_half;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: a segment scoreboard records every contiguous run of
// audio-high PLAY cycles (effect id, half-period, length) and compares it with
// the expected note sequence queued when each request is issued.
`timescale 1ns/1ps
module tb_sfx_scheduler;

  localparam int TICK      = 4;
  localparam int TICK_TONE = 1200;

  typedef struct packed {
    logic [1:0]  id;
    logic [16:0] half;
    logic [15:0] len;
  } seg_t;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [3:0]  req;
  logic        sfx;
  logic        busy;
  logic [1:0]  active_id;
  logic [16:0] tone_half;

  logic [3:0]  req_t;
  logic        sfx_t;
  logic        busy_t;
  logic [1:0]  active_id_t;
  logic [16:0] tone_half_t;

  int   checks = 0;
  int   errors = 0;
  seg_t exp_q[$];

  always #5 CLK = ~CLK;

  sfx_scheduler #(.TICK_CYCLES(TICK)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .REQ(req), .SFX_AUDIO(sfx),
    .BUSY(busy), .ACTIVE_ID(active_id), .TONE_HALF(tone_half)
  );

  sfx_scheduler #(.TICK_CYCLES(TICK_TONE)) dut_tone (
    .CLK(CLK), .RESET_N(RESET_N), .REQ(req_t), .SFX_AUDIO(sfx_t),
    .BUSY(busy_t), .ACTIVE_ID(active_id_t), .TONE_HALF(tone_half_t)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic seg_t mk(input logic [1:0] id, input logic [16:0] half, input int len);
    return {id, half, 16'(len)};
  endfunction

  task automatic push_lose();
    exp_q.push_back(mk(2'd3, 17'd51020, 400));
    exp_q.push_back(mk(2'd3, 17'd60606, 400));
    exp_q.push_back(mk(2'd3, 17'd76336, 400));
    exp_q.push_back(mk(2'd3, 17'd102041, 400));
  endtask

  task automatic pulse(input logic [3:0] r);
    @(negedge CLK);
    req = r;
    @(negedge CLK);
    req = 4'd0;
  endtask

  // Counts BUSY negedges starting at the current one; bounded.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      if (!busy) break;
      cnt++;
      @(negedge CLK);
    end
  endtask

  // Segment monitor / scoreboard consumer.
  initial begin : monitor
    logic        in_seg;
    logic [1:0]  seg_id;
    logic [16:0] seg_half;
    int          seg_len;
    int          nseg;
    seg_t        e;
    in_seg = 1'b0;
    seg_id = 2'd0;
    seg_half = 17'd0;
    seg_len = 0;
    nseg = 0;
    forever begin
      @(negedge CLK);
      if (sfx) begin
        if (!in_seg) begin
          in_seg   = 1'b1;
          seg_id   = active_id;
          seg_half = tone_half;
          seg_len  = 1;
        end else begin
          seg_len++;
        end
      end else if (in_seg) begin
        in_seg = 1'b0;
        if (exp_q.size() == 0) begin
          check($sformatf("seg%0d_unexpected", nseg), 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("seg%0d_id", nseg), 32'(seg_id), 32'(e.id));
          check($sformatf("seg%0d_half", nseg), 32'(seg_half), 32'(e.half));
          check($sformatf("seg%0d_len", nseg), 32'(seg_len), 32'(e.len));
        end
        nseg++;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cnt;
    int hi;
    int lo;
    RESET_N = 1'b0;
    req     = 4'd0;
    req_t   = 4'd0;
    repeat (3) @(negedge CLK);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sfx", 32'(sfx), 32'd0);
    check("rst_id", 32'(active_id), 32'd0);
    check("rst_half", 32'(tone_half), 32'd0);
    #2 RESET_N = 1'b1;

    // Long WALL tone on the slow-tick instance: audio toggles after one half-period.
    @(negedge CLK) req_t = 4'b0001;
    @(negedge CLK) req_t = 4'b0000;
    for (int i = 0; i < 10 && !sfx_t; i++) @(negedge CLK);
    hi = 0;
    while (sfx_t && hi < 30000) begin hi++; @(negedge CLK); end
    check("tone_high_cycles", 32'(hi), 32'd22727);
    lo = 0;
    while (busy_t && !sfx_t && lo < 30000) begin lo++; @(negedge CLK); end
    check("tone_low_cycles", 32'(lo), 32'd1273);
    check("tone_idle", 32'(busy_t), 32'd0);
    check("tone_idle_half", 32'(tone_half_t), 32'd0);

    // Single WALL.
    exp_q.push_back(mk(2'd0, 17'd22727, 80));
    pulse(4'b0001);
    check("wall_load_busy", 32'(busy), 32'd1);
    check("wall_load_sfx", 32'(sfx), 32'd0);
    wait_idle(cnt);
    check("wall_busy_cycles", 32'(cnt), 32'd81);
    check("wall_idle_half", 32'(tone_half), 32'd0);

    // BLOCK two-note sequence.
    exp_q.push_back(mk(2'd2, 17'd15163, 60));
    exp_q.push_back(mk(2'd2, 17'd11364, 60));
    pulse(4'b0100);
    check("block_load_id", 32'(active_id), 32'd2);
    wait_idle(cnt);
    check("block_busy_cycles", 32'(cnt), 32'd122);
    check("block_idle_id", 32'(active_id), 32'd0);
    check("block_idle_half", 32'(tone_half), 32'd0);

    // Simultaneous LOSE+PADDLE+WALL: LOSE first, then queued effects.
    push_lose();
    exp_q.push_back(mk(2'd1, 17'd45455, 120));
    exp_q.push_back(mk(2'd0, 17'd22727, 80));
    pulse(4'b1011);
    check("multi_load_id", 32'(active_id), 32'd3);
    wait_idle(cnt);
    check("multi_busy_cycles", 32'(cnt), 32'd1806);

    // PADDLE preempted by BLOCK; WALL queued during BLOCK.
    exp_q.push_back(mk(2'd1, 17'd45455, 11));
    exp_q.push_back(mk(2'd2, 17'd15163, 60));
    exp_q.push_back(mk(2'd2, 17'd11364, 60));
    exp_q.push_back(mk(2'd0, 17'd22727, 80));
    pulse(4'b0010);
    repeat (10) @(negedge CLK);
    pulse(4'b0100);
    check("preempt_id", 32'(active_id), 32'd2);
    check("preempt_sfx", 32'(sfx), 32'd0);
    repeat (20) @(negedge CLK);
    pulse(4'b0001);
    check("queued_id", 32'(active_id), 32'd2);
    wait_idle(cnt);

    // WALL restart extends the effect.
    exp_q.push_back(mk(2'd0, 17'd22727, 31));
    exp_q.push_back(mk(2'd0, 17'd22727, 80));
    pulse(4'b0001);
    repeat (30) @(negedge CLK);
    pulse(4'b0001);
    wait_idle(cnt);
    check("restart_busy_cycles", 32'(cnt), 32'd81);

    // Two PADDLE requests during LOSE collapse into one play.
    push_lose();
    exp_q.push_back(mk(2'd1, 17'd45455, 120));
    pulse(4'b1000);
    repeat (50) @(negedge CLK);
    pulse(4'b0010);
    repeat (500) @(negedge CLK);
    pulse(4'b0010);
    wait_idle(cnt);

    // Asynchronous reset in the middle of LOSE note 2, with PADDLE pending.
    exp_q.push_back(mk(2'd3, 17'd51020, 400));
    exp_q.push_back(mk(2'd3, 17'd60606, 49));
    pulse(4'b1000);
    repeat (100) @(negedge CLK);
    pulse(4'b0010);
    repeat (348) @(negedge CLK);
    check("pre_reset_half", 32'(tone_half), 32'd60606);
    #2 RESET_N = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_sfx", 32'(sfx), 32'd0);
    check("async_id", 32'(active_id), 32'd0);
    check("async_half", 32'(tone_half), 32'd0);
    repeat (3) @(negedge CLK);
    #2 RESET_N = 1'b1;
    repeat (20) @(negedge CLK);
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_sfx", 32'(sfx), 32'd0);

    check("sb_left", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
